// File: rtl/reset_ctrl_pkg.sv
// reset_ctrl_pkg: shared FSM encoding, CAUSE bit indices,
// register addresses and default hold length for reset_ctrl.
package reset_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int HOLD_CYCLES_DEF = 16;
  localparam int DB_CYCLES       = 8;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_WD  = 1;
  localparam int CAUSE_BTN = 2;
  localparam int CAUSE_SW  = 3;

  localparam logic [1:0] ADDR_CAUSE = 2'b00;
  localparam logic [1:0] ADDR_COUNT = 2'b01;

endpackage

// File: rtl/reset_ctrl_btn_cond.sv
// reset_ctrl_btn_cond: button sync, optional debounce
// (RSTCTRL_BTN_DEBOUNCE_EN), falling-edge event.
// Ports: clk, rst_n, btn_n (async button), evt (1-cycle pulse).
module reset_ctrl_btn_cond
  import reset_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic evt
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], btn_n};
  end

`ifdef RSTCTRL_BTN_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic [DW-1:0] db_cnt;
  logic          level;
  logic          level_d;
  logic          evt_q;

  // level follows sync only after DB_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
      evt_q   <= 1'b0;
    end else begin
      level_d <= level;
      evt_q   <= level_d & ~level;
      if (sync[1] == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign evt = evt_q;
`else
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= sync[1];
  end

  assign evt = prev & ~sync[1];
`endif

endmodule

// File: rtl/reset_ctrl.sv
// reset_ctrl: RUN/HOLD system reset sequencer with CAUSE,
// reset count and mem-map regs. Option: RSTCTRL_BTN_DEBOUNCE_EN.
// Ports: i_clk, i_rstn, i_wdReset, i_btnRstn, i_memAddr,
//   i_memDataIn, i_memWrEn, o_memDataOut, o_sysRstn, o_rstBusy.
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_wdReset,
  input  logic        i_btnRstn,
  input  logic [1:0]  i_memAddr,
  input  logic [15:0] i_memDataIn,
  input  logic        i_memWrEn,
  output logic [15:0] o_memDataOut,
  output logic        o_sysRstn,
  output logic        o_rstBusy
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_nxt;
  logic [3:0]    cause;
  logic [7:0]    rst_cnt;
  logic          btn_evt;
  logic          sw_req;
  logic          req;
  logic          run;
  logic          enter;
  logic [3:0]    cause_set;
  logic [3:0]    cause_clr;
  logic          unused_data;

  reset_ctrl_btn_cond u_btn (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .btn_n (i_btnRstn),
    .evt   (btn_evt)
  );

  assign sw_req = i_memWrEn & (i_memAddr == ADDR_COUNT)
                & i_memDataIn[0];
  assign req    = i_wdReset | btn_evt | sw_req;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // A request in HOLD restarts the count, even on the last cycle.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    unique case (state)
      ST_RUN: begin
        if (req) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
        end
      end
      ST_HOLD: begin
        if (req) begin
          hold_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    run       = (state == ST_RUN);
    o_rstBusy = ~run;
    enter     = run & req;
  end

  // Registered from the current state so the output drops
  // one cycle after the request edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) o_sysRstn <= 1'b0;
    else         o_sysRstn <= run;
  end

  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_WD]  = i_wdReset;
    cause_set[CAUSE_BTN] = btn_evt;
    cause_set[CAUSE_SW]  = sw_req;
    cause_clr            = '0;
    if (i_memWrEn && i_memAddr == ADDR_CAUSE)
      cause_clr = i_memDataIn[3:0];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cause   <= 4'b0001;
      rst_cnt <= '0;
    end else begin
      cause <= (cause & ~cause_clr) | cause_set;
      if (enter && rst_cnt != 8'hFF)
        rst_cnt <= rst_cnt + 8'd1;
    end
  end

  always_comb begin
    o_memDataOut = '0;
    unique case (1'b1)
      i_memAddr[1]:
        o_memDataOut = '0;
      (i_memAddr == ADDR_CAUSE):
        o_memDataOut = {o_rstBusy, 11'b0, cause};
      (i_memAddr == ADDR_COUNT):
        o_memDataOut = {8'b0, rst_cnt};
    endcase
  end

  assign unused_data = ^i_memDataIn[15:4];

endmodule

// File: tb/tb_reset_ctrl.sv
// tb_reset_ctrl: directed + random stimulus against a
// behavioural model of reset_ctrl, checked every cycle.
module tb_reset_ctrl;

  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wd;
  logic        btn;
  logic [1:0]  addr;
  logic [15:0] din;
  logic        wr;
  logic [15:0] dout;
  logic        sys;
  logic        busy;

  int errors = 0;
  int checks = 0;

  reset_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .i_clk        (clk),
    .i_rstn       (rst_n),
    .i_wdReset    (wd),
    .i_btnRstn    (btn),
    .i_memAddr    (addr),
    .i_memDataIn  (din),
    .i_memWrEn    (wr),
    .o_memDataOut (dout),
    .o_sysRstn    (sys),
    .o_rstBusy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model: hold tracked as cycles-remaining down-counter,
  // button as a history of raw samples.
  bit         m_busy;
  int         m_left;
  bit         m_sys;
  logic [3:0] m_cause;
  logic [7:0] m_count;
  logic [15:0] m_hist;
  bit         m_db;
  int         m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1;
      m_left  = HOLD;
      m_sys   = 0;
      m_cause = 4'b0001;
      m_count = 0;
      m_hist  = '1;
      m_db    = 1;
      m_pend  = 0;
    end else begin
      bit evt;
      bit sw;
      bit req;
      logic [3:0] clr;
`ifdef RSTCTRL_BTN_DEBOUNCE_EN
      evt = (m_pend == 1);
      if (m_pend > 0) m_pend--;
      if (m_hist[8:1] == {8{~m_db}}) begin
        m_db = ~m_db;
        if (!m_db) m_pend = 2;
      end
`else
      evt = m_hist[2] & ~m_hist[1];
`endif
      sw  = wr && addr == 2'd1 && din[0];
      req = wd || evt || sw;
      clr = (wr && addr == 2'd0) ? din[3:0] : 4'b0;
      m_cause = (m_cause & ~clr) | {sw, evt, wd, 1'b0};
      m_sys = !m_busy;
      if (req) begin
        if (!m_busy && m_count != 8'd255) m_count++;
        m_busy = 1;
        m_left = HOLD;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
      m_hist = {m_hist[14:0], btn};
    end
  end

  function automatic logic [15:0] m_rd(input logic [1:0] a);
    if (a == 2'd0) return {m_busy, 11'b0, m_cause};
    if (a == 2'd1) return {8'b0, m_count};
    return 16'h0000;
  endfunction

  always @(negedge clk) begin
    check("model_sys", 16'(sys), 16'(m_sys));
    check("model_busy", 16'(busy), 16'(m_busy));
    check("model_rd", dout, m_rd(addr));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a,
                    input logic [15:0] exp,
                    input string name);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic low_len(output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (sys) done = 1;
      else n++;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!busy && sys) ok = 1;
      else tick();
    end
    if (!ok) check("idle_timeout", 16'(ok), 16'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 0;
    wd    = 0;
    btn   = 1;
    wr    = 0;
    addr  = 0;
    din   = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sys", 16'(sys), 16'd0);
    check("rst_busy", 16'(busy), 16'd1);
    rd(2'd0, 16'h8001, "rst_cause");
    rst_n = 1;

    tick(16);
    check("por_sys_low", 16'(sys), 16'd0);
    check("por_busy_off", 16'(busy), 16'd0);
    tick();
    check("por_sys_high", 16'(sys), 16'd1);
    rd(2'd0, 16'h0001, "por_cause");
    rd(2'd1, 16'h0000, "por_count");

    wd = 1;
    tick();
    wd = 0;
    check("wd_sys_edge", 16'(sys), 16'd1);
    check("wd_busy", 16'(busy), 16'd1);
    rd(2'd0, 16'h8003, "wd_cause");
    low_len(n);
    check("wd_low_len", 16'(n), 16'd16);
    rd(2'd1, 16'h0001, "wd_count");

    wd = 1;
    tick();
    wd = 0;
    tick(9);
    addr = 2'd1;
    din  = 16'h0001;
    wr   = 1;
    tick();
    wr  = 0;
    din = 0;
    low_len(n);
    check("retrig_len", 16'(n), 16'd16);
    rd(2'd1, 16'h0002, "retrig_count");
    rd(2'd0, 16'h000B, "retrig_cause");

    addr = 2'd0;
    din  = 16'h000F;
    wr   = 1;
    wd   = 1;
    tick();
    wr  = 0;
    wd  = 0;
    din = 0;
    rd(2'd0, 16'h8002, "w1c_collision");
    wait_idle();
    rd(2'd1, 16'h0003, "w1c_count");

    btn = 0;
    tick(3);
    btn = 1;
`ifdef RSTCTRL_BTN_DEBOUNCE_EN
    tick(40);
    rd(2'd1, 16'h0003, "glitch_no_reset");
    btn = 0;
    tick(20);
    btn = 1;
    tick(20);
    wait_idle();
    rd(2'd1, 16'h0004, "press_count");
`else
    tick(10);
    wait_idle();
    rd(2'd1, 16'h0004, "glitch_count");
`endif
    rd(2'd0, 16'h0006, "btn_cause");

    for (int i = 0; i < 3000; i++) begin
      wd = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 24) == 0) btn = ~btn;
      wr   = ($urandom_range(0, 7) == 0);
      addr = 2'($urandom_range(0, 3));
      din  = 16'($urandom);
      tick();
    end
    wd  = 0;
    wr  = 0;
    btn = 1;
    din = 0;
    tick(30);
    wait_idle();

    for (int i = 0; i < 300; i++) begin
      wd = 1;
      tick();
      wd = 0;
      wait_idle();
    end
    rd(2'd1, 16'h00FF, "sat_count");
    rd(2'd2, 16'h0000, "rd_addr2");
    rd(2'd3, 16'h0000, "rd_addr3");
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_ctrl.md
RESET_CTRL -- requirements
Module: ResetCtrl

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, 16, cycles o_sysRstn is held low per reset event (legal 2..256).
REQ-002 SHALL have port: i_clk  input  1  single clock for all logic.
REQ-003 SHALL have port: i_rstn  input  1  asynchronous active-low power-on reset; only reset of this block.
REQ-004 SHALL have port: i_wdReset  input  1  synchronous one-cycle reset request from the watchdog.
REQ-005 SHALL have port: i_btnRstn  input  1  asynchronous active-low external button.
REQ-006 SHALL have port: i_memAddr  input  2  memory-map register select.
REQ-007 SHALL have port: i_memDataIn  input  16  memory-map write data.
REQ-008 SHALL have port: i_memWrEn  input  1  memory-map write strobe, one cycle per write.
REQ-009 SHALL have port: o_memDataOut  output  16  combinational memory-map read data.
REQ-010 SHALL have port: o_sysRstn  output  1  registered active-low system reset to all other blocks.
REQ-011 SHALL have port: o_rstBusy  output  1  high while the FSM is not in RUN.

Function
REQ-012 SHALL implement FSM states RUN and HOLD, with o_sysRstn = 1 only in RUN.
REQ-013 SHALL define request = i_wdReset | btnEvt | swReq; btnEvt = falling edge of the conditioned button; swReq = write to addr 01 with data bit0 = 1.
REQ-014 SHALL, on request in RUN at edge N, enter HOLD with hold counter 0; o_sysRstn is low from edge N+1.
REQ-015 SHALL, in HOLD, increment the hold counter each cycle and return to RUN when the counter reaches HOLD_CYCLES-1; o_sysRstn is high the cycle after.
REQ-016 SHALL, on request during HOLD, restart the hold counter at 0 (retrigger) and stay in HOLD.
REQ-017 SHALL keep a CAUSE register, bits[3:0] = {sw, button, watchdog, power-on}, each set by its source in any state.
REQ-018 SHALL clear CAUSE bits on a write to addr 00 where the data bit is 1 (W1C); a set event in the same cycle wins over the clear.
REQ-019 SHALL set all matching CAUSE bits when sources coincide.
REQ-020 SHALL keep an 8-bit reset counter that increments on each RUN->HOLD transition and saturates at 255; retriggers do not count.
REQ-021 SHALL return read data per address: 00 -> {o_rstBusy, 11'b0, CAUSE[3:0]}; 01 -> {8'b0, reset count}; 1X -> 16'h0000.
REQ-022 SHALL ignore writes to addresses 01 with bit0 = 0, and all writes to 1X.

Reset
REQ-023 SHALL, while i_rstn = 0, force state HOLD, hold counter 0, o_sysRstn 0, o_rstBusy 1, CAUSE 4'b0001, count 0, and button conditioning idle-high.
REQ-024 SHALL, after i_rstn deasserts, complete a full HOLD_CYCLES hold before o_sysRstn rises; this initial hold does not increment the count.
REQ-025 SHALL NOT be reset by o_sysRstn; CAUSE and count survive all non-power-on resets.

Configuration
REQ-026 SHALL, with RSTCTRL_BTN_DEBOUNCE_EN defined, condition i_btnRstn by a 2-flop synchronizer plus an 8-cycle stable-level debounce; btnEvt fires 1 cycle after the debounced level falls.
REQ-027 SHALL, without RSTCTRL_BTN_DEBOUNCE_EN, condition i_btnRstn by the 2-flop synchronizer only; btnEvt fires on the synchronized falling edge.

Structure
REQ-028 SHALL place the FSM state encoding, CAUSE bit indices, register address constants and the default HOLD_CYCLES in a shared package.
REQ-029 SHALL implement button conditioning (sync, optional debounce, edge detect) as sub-module BtnCond.

Verification
REQ-030 SHALL cover power-on: release i_rstn -> o_sysRstn low for 16 cycles, then 1; addr 00 reads 16'h0001; addr 01 reads 0.
REQ-031 SHALL cover watchdog: i_wdReset pulse at edge N in RUN -> o_sysRstn low from N+1 for 16 cycles; CAUSE bit1 set; count = 1.
REQ-032 SHALL cover retrigger: sw write 16'h0001 to addr 01 at hold cycle 10 -> hold extends to 16 cycles from the write; count unchanged; CAUSE bit3 set.
REQ-033 SHALL cover W1C collision: write 16'h000F to addr 00 in the same cycle as i_wdReset -> CAUSE reads 16'h8002 on the next cycle (busy, watchdog).
REQ-034 SHALL cover button: with the macro, a 3-cycle glitch produces no reset and a 20-cycle low press produces exactly one reset; without the macro, the 3-cycle glitch produces one reset.
REQ-035 SHALL cover saturation: 300 watchdog resets -> addr 01 reads 16'h00FF; a read of addr 2 returns 16'h0000.
